// File: rtl/camera_pkg.sv
// Shared camera pipeline definitions: pixel format, source geometry and
// the frame-capture state encoding.
package camera_pkg;
  localparam int RGB_W = 16;
  localparam int SRC_W = 640;
  localparam int SRC_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } cap_state_t;
endpackage

// File: rtl/camera_fb_writer_fifo.sv
// Small synchronous FIFO with show-ahead read data. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are control.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/camera_fb_writer.sv
// Decimates the camera pixel stream into a framebuffer window and writes
// kept pixels to external SRAM through a buffered req/ack port.
module camera_fb_writer
  import camera_pkg::*;
#(
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int DECIMATE  = 1,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 18,
  parameter int FIFO_AW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              pixel_valid,
  input  logic [RGB_W-1:0]  pixel_data,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RGB_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              frame_stored,
  output logic              overflow,
  output logic [7:0]        drop_count
);
  localparam int FW = ADDR_W + RGB_W;

  logic              vs_s1, vs_s2, vs_s3, vs_rise;
  cap_state_t        state, state_nx;
  logic              arm;
  logic [9:0]        x_p0, y_p0;
  logic              parity_ok_p0, keep_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              fifo_full, fifo_empty, pop, drop;
  logic [FW-1:0]     fifo_rd;

  function automatic logic [31:0] line_offset(input logic [9:0] yy);
    if (FB_W == 320) return ({22'd0, yy} << 8) + ({22'd0, yy} << 6);
    else             return {22'd0, yy} * 32'(FB_W);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end
  assign vs_rise = vs_s2 & ~vs_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    frame_stored = 1'b0;
    case (state)
      IDLE:    if (vs_rise && capture_en) state_nx = CAPTURE;
      CAPTURE: if (vs_rise) state_nx = DRAIN;
      DRAIN: begin
        if (fifo_empty && !mem_req) begin
          state_nx     = IDLE;
          frame_stored = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign arm = (state == IDLE) & vs_rise & capture_en;

  // p0: keep decision and SRAM address, both in the pixel's own cycle
  assign x_p0         = (DECIMATE != 0) ? {1'b0, col[9:1]} : col;
  assign y_p0         = (DECIMATE != 0) ? {1'b0, row[9:1]} : row;
  assign parity_ok_p0 = (DECIMATE == 0) || (!row[0] && !col[0]);
  assign keep_p0      = (state == CAPTURE) & pixel_valid & parity_ok_p0 &
                        ({22'd0, x_p0} < 32'(FB_W)) & ({22'd0, y_p0} < 32'(FB_H));
  assign addr_p0      = ADDR_W'(32'(BASE_ADDR) + line_offset(y_p0) + {22'd0, x_p0});

  assign pop  = ~fifo_empty & (~mem_req | mem_ack);
  assign drop = keep_p0 & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (FW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (keep_p0),
    .wr_data ({addr_p0, pixel_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (arm) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // p1: SRAM request register, reloaded back-to-back on ack while entries remain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pop) begin
      mem_req                <= 1'b1;
      {mem_addr, mem_wdata}  <= fifo_rd;
    end else if (mem_req && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  assign busy = (state != IDLE) | ~fifo_empty | mem_req;
endmodule

// File: tb/tb_camera_fb_writer.sv
// Scoreboard bench: stimulus pushes expected SRAM writes, a monitor pops and
// compares them as the writers complete requests.
module tb_camera_fb_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic        vsync1 = 1'b0, vsync0 = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [9:0]  row = '0, col = '0;
  logic        ack1 = 1'b0;
  logic        ack0;
  logic        mem_req1, mem_req0, busy1, busy0, fs1, fs0, ovf1, ovf0;
  logic [17:0] mem_addr1, mem_addr0;
  logic [15:0] mem_wdata1, mem_wdata0;
  logic [7:0]  drop1, drop0;

  int checks = 0, errors = 0;
  int fs1_cnt = 0, fs0_cnt = 0, fs1_exp = 0, fs0_exp = 0;
  int m1_st = 0, m0_st = 0;      // 0 idle, 1 capturing, 2 draining
  int m1_drops = 0;
  int ack_mode = 0;              // 0 held low, 1 held high, 2 random
  logic [33:0] q1[$], q0[$];
  logic [33:0] e;

  assign ack0 = 1'b1;
  always #5 clk = ~clk;

  camera_fb_writer dut1 (
    .clk(clk), .reset(reset), .capture_en(capture_en), .vsync(vsync1),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .row(row), .col(col),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ack(ack1),
    .busy(busy1), .frame_stored(fs1), .overflow(ovf1), .drop_count(drop1));

  camera_fb_writer #(.DECIMATE(0)) dut0 (
    .clk(clk), .reset(reset), .capture_en(capture_en), .vsync(vsync0),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .row(row), .col(col),
    .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ack(ack0),
    .busy(busy0), .frame_stored(fs0), .overflow(ovf0), .drop_count(drop0));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference placement: which framebuffer word a source pixel lands in, if any.
  function automatic bit place(input bit dec, input int r, input int c, output int addr);
    int x, y;
    if (dec && ((r % 2) != 0 || (c % 2) != 0)) return 0;
    x = dec ? c / 2 : c;
    y = dec ? r / 2 : r;
    addr = y * 320 + x;
    return (x < 320) && (y < 240);
  endfunction

  task automatic send_pixel(input int r, input int c, input logic [15:0] d);
    int a;
    row = r[9:0]; col = c[9:0]; pixel_data = d; pixel_valid = 1'b1;
    if (m1_st == 1 && place(1'b1, r, c, a)) begin
      // With acks held off, eight FIFO entries plus the request register hold nine pixels.
      if (ack_mode == 0 && q1.size() >= 9) m1_drops++;
      else q1.push_back({a[17:0], d});
    end
    if (m0_st == 1 && place(1'b0, r, c, a)) q0.push_back({a[17:0], d});
    tick();
    pixel_valid = 1'b0;
    tick();
  endtask

  task automatic vs_pulse(input int which, input logic cap);
    capture_en = cap;
    if (which == 1) vsync1 = 1'b1; else vsync0 = 1'b1;
    repeat (4) tick();
    vsync1 = 1'b0; vsync0 = 1'b0;
    repeat (3) tick();
    if (which == 1) begin
      if (m1_st == 0 && cap) begin m1_st = 1; m1_drops = 0; end
      else if (m1_st == 1) m1_st = 2;
    end else begin
      if (m0_st == 0 && cap) m0_st = 1;
      else if (m0_st == 1) m0_st = 2;
    end
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    if (which == 1) begin
      fs1_exp++;
      while (n < 3000 && !(q1.size() == 0 && !busy1 && fs1_cnt >= fs1_exp)) begin tick(); n++; end
      chk("frame_stored_count1", fs1_cnt, fs1_exp);
      chk("pending_writes1", q1.size(), 0);
      m1_st = 0;
    end else begin
      fs0_exp++;
      while (n < 3000 && !(q0.size() == 0 && !busy0 && fs0_cnt >= fs0_exp)) begin tick(); n++; end
      chk("frame_stored_count0", fs0_cnt, fs0_exp);
      chk("pending_writes0", q0.size(), 0);
      m0_st = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       ack1 = 1'b0;
        1:       ack1 = 1'b1;
        default: ack1 = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req1 && ack1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL wr1_unexpected actual addr=%0d data=%h required=none", mem_addr1, mem_wdata1);
        end else begin
          e = q1.pop_front();
          if ({mem_addr1, mem_wdata1} !== e) begin
            errors++;
            $display("FAIL wr1 actual addr=%0d data=%h required addr=%0d data=%h",
                     mem_addr1, mem_wdata1, e[33:16], e[15:0]);
          end
        end
      end
      if (mem_req0 && ack0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL wr0_unexpected actual addr=%0d data=%h required=none", mem_addr0, mem_wdata0);
        end else begin
          e = q0.pop_front();
          if ({mem_addr0, mem_wdata0} !== e) begin
            errors++;
            $display("FAIL wr0 actual addr=%0d data=%h required addr=%0d data=%h",
                     mem_addr0, mem_wdata0, e[33:16], e[15:0]);
          end
        end
      end
      if (fs1) fs1_cnt++;
      if (fs0) fs0_cnt++;
    end
  end

  initial begin
    repeat (3) tick();
    chk("reset_mem_req", mem_req1, 0);
    chk("reset_outputs", {mem_addr1, mem_wdata1, busy1, fs1, ovf1, drop1}, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy1, 0);

    // Reset while a request is outstanding
    ack_mode = 0;
    vs_pulse(1, 1'b1);
    send_pixel(0, 0, 16'h1234);
    repeat (3) tick();
    chk("req_before_reset", mem_req1, 1);
    reset = 1'b1;
    #1;
    chk("reset_mid_req", mem_req1, 0);
    chk("reset_mid_busy", busy1, 0);
    chk("reset_mid_outputs", {mem_addr1, mem_wdata1, fs1, ovf1, drop1}, 0);
    q1.delete();
    m1_st = 0;
    repeat (2) tick();
    reset = 1'b0;
    ack_mode = 1;
    repeat (2) tick();

    // Decimation, window edges and back-to-back writes
    vs_pulse(1, 1'b1);
    chk("armed_busy", busy1, 1);
    send_pixel(2, 4, 16'hF800);
    send_pixel(1, 4, 16'h0001);
    send_pixel(2, 3, 16'h0002);
    send_pixel(480, 0, 16'h0003);
    send_pixel(0, 640, 16'h0004);
    send_pixel(478, 638, 16'h07E0);
    for (int i = 0; i < 4; i++) send_pixel(10, 2 * i, 16'hA000 + 16'(i));
    chk("b2b_drops", drop1, 0);
    vs_pulse(1, 1'b1);
    wait_done(1);

    // Unarmed frame start, then armed frame with overflow
    vs_pulse(1, 1'b0);
    send_pixel(4, 4, 16'hBEEF);
    repeat (4) tick();
    chk("unarmed_busy", busy1, 0);
    ack_mode = 0;
    repeat (2) tick();
    vs_pulse(1, 1'b1);
    for (int i = 0; i < 11; i++) send_pixel(20, 2 * i, 16'hC000 + 16'(i));
    chk("overflow_flag", ovf1, 1);
    chk("overflow_drops", drop1, m1_drops);
    chk("overflow_drops_two", drop1, 2);
    ack_mode = 1;
    repeat (20) tick();
    vs_pulse(1, 1'b1);
    wait_done(1);

    // Frame start during drain is ignored
    ack_mode = 0;
    repeat (2) tick();
    vs_pulse(1, 1'b1);
    chk("rearm_clears_overflow", ovf1, 0);
    chk("rearm_clears_drops", drop1, 0);
    for (int i = 0; i < 3; i++) send_pixel(30, 4 * i, 16'h5A00 + 16'(i));
    vs_pulse(1, 1'b1);
    vs_pulse(1, 1'b1);
    send_pixel(32, 0, 16'hDEAD);
    ack_mode = 1;
    wait_done(1);
    repeat (20) tick();
    chk("single_frame_stored", fs1_cnt, fs1_exp);
    chk("drained_busy", busy1, 0);

    // Randomised frame with random acks
    ack_mode = 2;
    vs_pulse(1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (q1.size() < 6)
        send_pixel(int'($urandom_range(0, 500)), int'($urandom_range(0, 660)), 16'($urandom));
      else tick();
    end
    chk("random_drops", drop1, 0);
    ack_mode = 1;
    vs_pulse(1, 1'b1);
    wait_done(1);

    // Undecimated writer window
    vs_pulse(0, 1'b1);
    send_pixel(0, 320, 16'h1111);
    send_pixel(239, 319, 16'h2222);
    send_pixel(3, 5, 16'h3333);
    send_pixel(240, 0, 16'h4444);
    send_pixel(1, 1, 16'h5555);
    vs_pulse(0, 1'b1);
    wait_done(0);
    chk("nodec_drops", drop0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
